// File: rtl/cache_loader.sv
`default_nettype none
// ============================================================================
// Module   : cache_loader
// Purpose  : Streams a 2^ADDR_W byte image from the host link into the ROM-cache
//            SRAM while holding the Z80 bus. Optional macro: CACHE_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_loader #(
    parameter int          ADDR_W    = 14,
    parameter int          WE_CYCLES = 2,
    parameter int          TIMEOUT   = 1000000,
    parameter logic [7:0]  SYNC_BYTE = 8'h55
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              busack_n,
    output logic              busrq_n,
    output logic              bus_own,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_a14,
    output logic [7:0]        sram_d,
    output logic              sram_d_oe,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              done,
    output logic              err
);

    localparam int c_TO_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_BANK   = 4'd1;
    localparam logic [3:0] c_REQ    = 4'd2;
    localparam logic [3:0] c_WAIT   = 4'd3;
    localparam logic [3:0] c_SETUP  = 4'd4;
    localparam logic [3:0] c_STROBE = 4'd5;
    localparam logic [3:0] c_HOLD   = 4'd6;
    localparam logic [3:0] c_FINISH = 4'd7;
`ifdef CACHE_LOADER_CHECKSUM_EN
    localparam logic [3:0] c_CHECK  = 4'd8;
`endif

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [1:0]        r_ack_sync;
    logic [3:0]        r_we_cnt;
    logic [c_TO_W-1:0] r_to_cnt;

    logic w_granted;
    logic w_accept;
    logic w_timed;
    logic w_timeout;
    logic w_last;
    logic w_we_last;
    logic w_sum_bad;
    logic w_err_set;
    logic w_err_clr;

    logic w_rx_ready;
    logic w_busrq_n;
    logic w_bus_own;
    logic w_ce_n;
    logic w_we_n;
    logic w_d_oe;
    logic w_done;

    assign w_granted = ~r_ack_sync[1];
    assign w_accept  = rx_valid & rx_ready;
    assign w_last    = (sram_a == {ADDR_W{1'b1}});
    assign w_we_last = (r_we_cnt == 4'(WE_CYCLES - 1));
    assign sram_oe_n = 1'b1;

`ifdef CACHE_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    assign w_timed   = (r_state == c_BANK) || (r_state == c_WAIT) || (r_state == c_CHECK);
    assign w_sum_bad = (r_state == c_CHECK) && w_accept && (rx_data != r_sum);
`else
    assign w_timed   = (r_state == c_BANK) || (r_state == c_WAIT);
    assign w_sum_bad = 1'b0;
`endif

    // The counter measures idle clocks since the last accepted byte in a waiting state
    assign w_timeout = w_timed && !w_accept && (r_to_cnt == c_TO_W'(TIMEOUT - 1));
    assign w_err_set = w_timeout | w_sum_bad;
    assign w_err_clr = (r_state == c_IDLE) && w_accept && (rx_data == SYNC_BYTE);

    // State register; pin outputs are registered from the next-state decode so they
    // change glitch-free on the same edge as the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            rx_ready  <= 1'b0;
            busrq_n   <= 1'b1;
            bus_own   <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_d_oe <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_next;
            rx_ready  <= w_rx_ready;
            busrq_n   <= w_busrq_n;
            bus_own   <= w_bus_own;
            sram_ce_n <= w_ce_n;
            sram_we_n <= w_we_n;
            sram_d_oe <= w_d_oe;
            done      <= w_done;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept && (rx_data == SYNC_BYTE)) w_next = c_BANK;
            end
            c_BANK: begin
                if (w_timeout)     w_next = c_IDLE;
                else if (w_accept) w_next = c_REQ;
            end
            c_REQ: begin
                if (w_granted) w_next = c_WAIT;
            end
            c_WAIT: begin
                if (w_timeout)     w_next = c_IDLE;
                else if (w_accept) w_next = c_SETUP;
            end
            c_SETUP:  w_next = c_STROBE;
            c_STROBE: begin
                if (w_we_last) w_next = c_HOLD;
            end
            c_HOLD: begin
`ifdef CACHE_LOADER_CHECKSUM_EN
                w_next = w_last ? c_CHECK : c_WAIT;
`else
                w_next = w_last ? c_FINISH : c_WAIT;
`endif
            end
`ifdef CACHE_LOADER_CHECKSUM_EN
            c_CHECK: begin
                if (w_timeout)      w_next = c_IDLE;
                else if (w_sum_bad) w_next = c_IDLE;
                else if (w_accept)  w_next = c_FINISH;
            end
`endif
            c_FINISH: w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_rx_ready = 1'b0;
        w_busrq_n  = 1'b1;
        w_bus_own  = 1'b0;
        w_ce_n     = 1'b1;
        w_we_n     = 1'b1;
        w_d_oe     = 1'b0;
        w_done     = 1'b0;
        case (w_next)
            c_IDLE, c_BANK: w_rx_ready = 1'b1;
            c_REQ:          w_busrq_n  = 1'b0;
            c_WAIT: begin
                w_rx_ready = 1'b1;
                w_busrq_n  = 1'b0;
                w_bus_own  = 1'b1;
                w_ce_n     = 1'b0;
            end
            c_SETUP, c_HOLD: begin
                w_busrq_n  = 1'b0;
                w_bus_own  = 1'b1;
                w_ce_n     = 1'b0;
                w_d_oe     = 1'b1;
            end
            c_STROBE: begin
                w_busrq_n  = 1'b0;
                w_bus_own  = 1'b1;
                w_ce_n     = 1'b0;
                w_d_oe     = 1'b1;
                w_we_n     = 1'b0;
            end
`ifdef CACHE_LOADER_CHECKSUM_EN
            c_CHECK: begin
                w_rx_ready = 1'b1;
                w_busrq_n  = 1'b0;
                w_bus_own  = 1'b1;
                w_ce_n     = 1'b0;
            end
`endif
            c_FINISH: w_done = 1'b1;
            default: ;
        endcase
    end

    // BUSACK is asynchronous to clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ack_sync <= 2'b11;
        else       r_ack_sync <= {r_ack_sync[0], busack_n};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_we_cnt <= '0;
            sram_a   <= '0;
            sram_a14 <= 1'b0;
            sram_d   <= '0;
            err      <= 1'b0;
        end else begin
            if (w_timed && !w_accept) r_to_cnt <= r_to_cnt + 1'b1;
            else                      r_to_cnt <= '0;

            if (r_state == c_STROBE) r_we_cnt <= r_we_cnt + 1'b1;
            else                     r_we_cnt <= '0;

            if ((r_state == c_REQ) && w_granted)      sram_a <= '0;
            else if ((r_state == c_HOLD) && !w_last)  sram_a <= sram_a + 1'b1;

            if ((r_state == c_BANK) && w_accept) sram_a14 <= rx_data[0];
            if ((r_state == c_WAIT) && w_accept) sram_d   <= rx_data;

            if (w_err_set)      err <= 1'b1;
            else if (w_err_clr) err <= 1'b0;
        end
    end

`ifdef CACHE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                r_sum <= '0;
        else if ((r_state == c_BANK) && w_accept) r_sum <= '0;
        else if ((r_state == c_WAIT) && w_accept) r_sum <= r_sum + rx_data;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_loader
// Purpose  : Directed self-checking bench for cache_loader (ADDR_W=4, TIMEOUT=50).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_loader;

    localparam int         c_AW   = 4;
    localparam int         c_WE   = 2;
    localparam int         c_TO   = 50;
    localparam logic [7:0] c_SYNC = 8'h55;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            busack_n = 1'b1;
    logic            rx_ready, busrq_n, bus_own, sram_a14, sram_d_oe;
    logic            sram_ce_n, sram_we_n, sram_oe_n, done, err;
    logic [c_AW-1:0] sram_a;
    logic [7:0]      sram_d;

    int errors = 0;
    int checks = 0;
    int grant_delay = 5;

    cache_loader #(.ADDR_W(c_AW), .WE_CYCLES(c_WE), .TIMEOUT(c_TO), .SYNC_BYTE(c_SYNC)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .busack_n(busack_n), .busrq_n(busrq_n), .bus_own(bus_own), .sram_a(sram_a),
        .sram_a14(sram_a14), .sram_d(sram_d), .sram_d_oe(sram_d_oe), .sram_ce_n(sram_ce_n),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Z80 model: grants the bus grant_delay clocks after BUSRQ falls
    int gcnt = 0;
    always @(negedge clk) begin
        if (busrq_n === 1'b0) begin
            if (gcnt >= grant_delay) busack_n = 1'b0;
            gcnt++;
        end else begin
            gcnt = 0;
            busack_n = 1'b1;
        end
    end

    // Write logger: one entry per sram_we_n low pulse
    int         wr_cnt = 0, done_cnt = 0, strobe_cnt = 0, low_len = 0;
    logic [7:0] wr_a [128];
    logic [7:0] wr_d [128];
    int         wr_len [128];
    logic       wr_a14 [128];
    logic       wr_ok [128];
    logic       prev_we = 1'b1;
    logic [7:0] cap_a, cap_d;
    logic       cap_a14, cap_ok;
    always @(negedge clk) begin
        if (sram_we_n === 1'b0) begin
            if (prev_we === 1'b1) begin
                cap_a   = 8'(sram_a);
                cap_d   = sram_d;
                cap_a14 = sram_a14;
                cap_ok  = (bus_own === 1'b1) && (sram_ce_n === 1'b0) && (sram_d_oe === 1'b1) && (sram_oe_n === 1'b1);
                low_len = 0;
                strobe_cnt++;
            end
            low_len++;
        end else if (prev_we === 1'b0) begin
            if (wr_cnt < 128) begin
                wr_a[wr_cnt]   = cap_a;
                wr_d[wr_cnt]   = cap_d;
                wr_len[wr_cnt] = low_len;
                wr_a14[wr_cnt] = cap_a14;
                wr_ok[wr_cnt]  = cap_ok;
            end
            wr_cnt++;
        end
        if (done === 1'b1) done_cnt++;
        prev_we = sram_we_n;
    end

    // Offers one byte starting at a falling edge; got=1 once it has been taken
    task automatic send_byte(input logic [7:0] b, input int max_wait, output bit got);
        int n;
        got = 1'b0;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!got && n < max_wait) begin
            if (rx_ready === 1'b1) got = 1'b1;
            @(negedge clk);
            n++;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] bank, input logic [7:0] seed, input int nbytes,
                             output int acc, output logic [7:0] sum);
        bit g;
        acc = 0;
        sum = 8'h00;
        send_byte(c_SYNC, 20, g); acc += int'(g);
        send_byte(bank, 20, g);   acc += int'(g);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(seed ^ 8'(i), 400, g);
            acc += int'(g);
            sum += seed ^ 8'(i);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busrq_n, bus_own, sram_ce_n, sram_we_n, sram_oe_n, sram_d_oe} !== 6'b101110) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 101110", {busrq_n, bus_own, sram_ce_n, sram_we_n, sram_oe_n, sram_d_oe});
        end
        checks++;
        if ({sram_a, sram_a14, sram_d, rx_ready, done, err} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0000", {sram_a, sram_a14, sram_d, rx_ready, done, err});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b expected 1", rx_ready);
        end
    endtask

    task automatic test_full_load;
        int acc, base, d0;
        logic [7:0] sum;
        bit g;
        grant_delay = 5;
        base = wr_cnt;
        d0 = done_cnt;
        send_load(8'h01, 8'h00, 16, acc, sum);
`ifdef CACHE_LOADER_CHECKSUM_EN
        send_byte(sum, 20, g); acc += int'(g);
        checks++;
        if (acc !== 19) begin errors++; $display("FAIL full_accepted: got %0d expected 19", acc); end
`else
        g = 1'b0;
        checks++;
        if (acc !== 18) begin errors++; $display("FAIL full_accepted: got %0d expected 18", acc); end
`endif
        repeat (10) @(negedge clk);
        checks++;
        if (wr_cnt - base !== 16) begin errors++; $display("FAIL full_writes: got %0d expected 16", wr_cnt - base); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({wr_a[base+i], wr_d[base+i], 8'(wr_len[base+i]), wr_a14[base+i], wr_ok[base+i]} !== {8'(i), 8'(i), 8'd2, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL full_write%0d: got a=%h d=%h len=%0d a14=%b ok=%b expected a=%h d=%h len=2 a14=1 ok=1",
                         i, wr_a[base+i], wr_d[base+i], wr_len[base+i], wr_a14[base+i], wr_ok[base+i], i, i);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done: got %0d pulses expected 1", done_cnt - d0); end
        checks++;
        if ({busrq_n, bus_own, sram_ce_n, sram_d_oe, err, rx_ready} !== 6'b101001) begin
            errors++;
            $display("FAIL full_release: got %b expected 101001", {busrq_n, bus_own, sram_ce_n, sram_d_oe, err, rx_ready});
        end
    endtask

    task automatic test_garbage;
        int acc, base, d0, bad;
        logic [7:0] sum;
        bit g1, g2;
        base = wr_cnt;
        d0 = done_cnt;
        send_byte(8'hAA, 20, g1);
        send_byte(8'h00, 20, g2);
        repeat (8) @(negedge clk);
        checks++;
        if ({g1, g2, busrq_n, rx_ready} !== 4'b1111) begin
            errors++;
            $display("FAIL garbage_ignored: got %b expected 1111", {g1, g2, busrq_n, rx_ready});
        end
        send_load(8'h00, 8'hF0, 16, acc, sum);
`ifdef CACHE_LOADER_CHECKSUM_EN
        send_byte(sum, 20, g1);
`endif
        repeat (10) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if ({wr_a[base+i], wr_d[base+i], wr_a14[base+i]} !== {8'(i), 8'hF0 ^ 8'(i), 1'b0}) bad++;
        checks++;
        if ({wr_cnt - base, bad} !== {32'd16, 32'd0}) begin
            errors++;
            $display("FAIL garbage_writes: got %0d writes %0d wrong expected 16 writes 0 wrong", wr_cnt - base, bad);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL garbage_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_timeout;
        int acc, base, d0;
        logic [7:0] sum;
        bit g;
        base = wr_cnt;
        d0 = done_cnt;
        send_load(8'h00, 8'h00, 3, acc, sum);
        repeat (30) @(negedge clk);
        checks++;
        if ({err, busrq_n} !== 2'b00) begin errors++; $display("FAIL timeout_early: got err,busrq_n=%b expected 00", {err, busrq_n}); end
        repeat (40) @(negedge clk);
        checks++;
        if ({err, busrq_n, sram_d_oe, bus_own, sram_ce_n} !== 5'b11001) begin
            errors++;
            $display("FAIL timeout_release: got %b expected 11001", {err, busrq_n, sram_d_oe, bus_own, sram_ce_n});
        end
        checks++;
        if ({done_cnt - d0, wr_cnt - base} !== {32'd0, 32'd3}) begin
            errors++;
            $display("FAIL timeout_counts: got done=%0d writes=%0d expected done=0 writes=3", done_cnt - d0, wr_cnt - base);
        end
        send_byte(c_SYNC, 20, g);
        checks++;
        if ({g, err} !== 2'b10) begin errors++; $display("FAIL timeout_sync_clears: got %b expected 10", {g, err}); end
        repeat (70) @(negedge clk);
        checks++;
        if ({err, rx_ready, busrq_n} !== 3'b111) begin
            errors++;
            $display("FAIL bank_timeout: got %b expected 111", {err, rx_ready, busrq_n});
        end
    endtask

    task automatic test_delayed_grant;
        int base, d0, s0, rq_bad, rdy_bad, err_bad, acc;
        logic [7:0] sum;
        bit g1, g2;
        grant_delay = 200;
        base = wr_cnt;
        d0 = done_cnt;
        s0 = strobe_cnt;
        rq_bad = 0; rdy_bad = 0; err_bad = 0;
        send_byte(c_SYNC, 20, g1);
        send_byte(8'h00, 20, g2);
        for (int i = 0; i < 190; i++) begin
            if (busrq_n !== 1'b0) rq_bad++;
            if (rx_ready !== 1'b0) rdy_bad++;
            if (err !== 1'b0) err_bad++;
            @(negedge clk);
        end
        checks++;
        if ({rq_bad, rdy_bad, err_bad, strobe_cnt - s0} !== 128'd0) begin
            errors++;
            $display("FAIL grant_wait: got busrq_bad=%0d ready_bad=%0d err_bad=%0d strobes=%0d expected all 0",
                     rq_bad, rdy_bad, err_bad, strobe_cnt - s0);
        end
        acc = 0;
        sum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h3C ^ 8'(i), 400, g1);
            acc += int'(g1);
            sum += 8'h3C ^ 8'(i);
        end
`ifdef CACHE_LOADER_CHECKSUM_EN
        send_byte(sum, 20, g1);
`endif
        repeat (10) @(negedge clk);
        checks++;
        if ({acc, wr_cnt - base, done_cnt - d0} !== {32'd16, 32'd16, 32'd1}) begin
            errors++;
            $display("FAIL grant_load: got acc=%0d writes=%0d done=%0d expected 16 16 1", acc, wr_cnt - base, done_cnt - d0);
        end
        checks++;
        if ({wr_a[base+15], wr_d[base+15]} !== {8'h0F, 8'h33}) begin
            errors++;
            $display("FAIL grant_last_write: got a=%h d=%h expected a=0f d=33", wr_a[base+15], wr_d[base+15]);
        end
        grant_delay = 5;
    endtask

    task automatic test_reset_midload;
        int acc, d0;
        logic [7:0] sum;
        d0 = done_cnt;
        send_load(8'h01, 8'h00, 8, acc, sum);
        @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b0) begin errors++; $display("FAIL midload_strobe: got we_n=%b expected 0", sram_we_n); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({sram_we_n, busrq_n, sram_ce_n, bus_own, sram_d_oe} !== 5'b11100) begin
            errors++;
            $display("FAIL midload_release: got %b expected 11100", {sram_we_n, busrq_n, sram_ce_n, bus_own, sram_d_oe});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({done_cnt - d0, 31'd0, rx_ready} !== {32'd0, 32'd1}) begin
            errors++;
            $display("FAIL midload_after: got done=%0d rx_ready=%b expected done=0 rx_ready=1", done_cnt - d0, rx_ready);
        end
    endtask

`ifdef CACHE_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        int acc, base, d0;
        logic [7:0] sum;
        bit g;
        d0 = done_cnt;
        send_load(8'h01, 8'h00, 16, acc, sum);
        send_byte(8'h78, 20, g);
        repeat (6) @(negedge clk);
        checks++;
        if ({g, done_cnt - d0, 31'd0, err} !== {1'b1, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL checksum_good: got acc=%b done=%0d err=%b expected 1 1 0", g, done_cnt - d0, err);
        end
        base = wr_cnt;
        d0 = done_cnt;
        send_load(8'h01, 8'h00, 16, acc, sum);
        send_byte(8'h77, 20, g);
        repeat (6) @(negedge clk);
        checks++;
        if ({err, busrq_n, bus_own, done_cnt - d0, wr_cnt - base} !== {3'b110, 32'd0, 32'd16}) begin
            errors++;
            $display("FAIL checksum_bad: got err=%b busrq_n=%b own=%b done=%0d writes=%0d expected 1 1 0 0 16",
                     err, busrq_n, bus_own, done_cnt - d0, wr_cnt - base);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_full_load;
        test_garbage;
        test_timeout;
        test_delayed_grant;
        test_reset_midload;
`ifdef CACHE_LOADER_CHECKSUM_EN
        test_checksum;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_loader.md
Name: cache_loader

Overview:
- Upstream fill stage for the ROM-cache SRAM on the Z80 debug board.
- Takes a byte stream from the host link receiver and requests the Z80 bus via BUSRQ.
- Once the bus is granted, writes a full 16 KB image into the selected cache bank, then releases the bus.
- Drives the SRAM pins through bus_own; the cache decoder passes them through while bus_own=1.

Parameters:
- ADDR_W, 14, SRAM address width; image length = 2^ADDR_W bytes.
- WE_CYCLES, 2, clocks sram_we_n is held low per byte (1..15).
- TIMEOUT, 1000000, max clocks between received bytes once a session starts.
- SYNC_BYTE, 8'h55, session start marker.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  byte available from link receiver.
- rx_data  in  8  received byte.
- rx_ready  out  1  byte accepted when rx_valid & rx_ready at clk edge.
- busack_n  in  1  Z80 BUSACK, asynchronous, active-low.
- busrq_n  out  1  Z80 BUSRQ, active-low.
- bus_own  out  1  loader owns SRAM pins.
- sram_a  out  ADDR_W  SRAM address.
- sram_a14  out  1  bank select during load.
- sram_d  out  8  write data.
- sram_d_oe  out  1  data bus drive enable.
- sram_ce_n  out  1  SRAM chip enable.
- sram_we_n  out  1  SRAM write strobe.
- sram_oe_n  out  1  SRAM output enable; constant 1 while bus_own.
- done  out  1  one-clock pulse on successful load.
- err  out  1  sticky error; cleared by the next SYNC_BYTE or by reset.

Behaviour:
- Reset values (applied immediately, async): busrq_n=1, bus_own=0, sram_ce_n=1, sram_we_n=1, sram_oe_n=1, sram_d_oe=0, sram_a=0, sram_a14=0, sram_d=0, rx_ready=0, done=0, err=0; state IDLE.
- busack_n passes through a 2-FF synchronizer; grant is seen 2-3 clocks after the pin falls.
- IDLE:
  - rx_ready=1.
  - Byte == SYNC_BYTE: clear err, go BANK.
  - Any other byte is discarded.
- BANK:
  - rx_ready=1.
  - Accept a byte; sram_a14 <= byte[0]; go REQ.
- REQ:
  - busrq_n=0, rx_ready=0.
  - Wait for synced busack_n=0, then bus_own=1, sram_ce_n=0, sram_a=0; go WAIT_BYTE.
- WAIT_BYTE:
  - rx_ready=1.
  - On accept: sram_d <= byte, sram_d_oe=1, rx_ready=0; go SETUP.
- SETUP:
  - One clock; address and data are stable.
  - Go STROBE.
- STROBE:
  - sram_we_n=0 for exactly WE_CYCLES clocks.
  - Go HOLD.
- HOLD:
  - sram_we_n=1; address and data held one clock.
  - If sram_a == 2^ADDR_W-1: go FINISH (or CHECK with the option).
  - Otherwise sram_a increments and state returns to WAIT_BYTE.
- FINISH:
  - sram_d_oe=0, sram_ce_n=1, bus_own=0, busrq_n=1.
  - done=1 for one clock; go IDLE.
- Address never wraps during a load; the last write is at all-ones.
- Timeout:
  - Counter resets on every accepted byte.
  - If it reaches TIMEOUT in BANK or WAIT_BYTE: err=1, release as in FINISH but with no done pulse; go IDLE.
  - The timeout is not active in REQ; the CPU must grant.
- Throughput: one byte per 3+WE_CYCLES clocks minimum; rx_ready is low between bytes.
- rx_valid while rx_ready=0 is not consumed; the upstream receiver holds the byte.
- Reset mid-load: bus released in the same instant, SRAM contents undefined, no done pulse.

Optional Feature:
- Macro: CACHE_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps an 8-bit running sum (mod 256) of the image bytes.
  - After the last HOLD it enters CHECK with rx_ready=1 and accepts one more byte, still subject to the timeout.
  - Match: FINISH with done pulse.
  - Mismatch: err=1, release, no done pulse.
  - The SRAM data is already written either way.
- Not defined: no CHECK state, no checksum byte, done follows the last write.

Test Plan:
- Full load, ADDR_W=4, WE_CYCLES=2: send 55, 01, then bytes 00..0F, busack_n low 5 clocks after busrq_n falls -> 16 writes at a=0..15 with d=a, sram_a14=1, we_n low 2 clocks each, done pulse, busrq_n=1, bus_own=0.
- Garbage before sync: send AA, 00, then 55, 00 plus 16 bytes -> first two bytes ignored, load into bank 0, done pulse.
- Timeout, TIMEOUT=50: send 55, 00, 3 data bytes, then silence -> err=1 after 50 clocks, busrq_n=1, sram_d_oe=0, no done; next 55 clears err.
- Delayed grant: busack_n held high for 200 clocks -> busrq_n stays 0, rx_ready=0, no SRAM strobe, no err; load completes after the grant.
- Reset mid-load: assert reset after byte 7 during STROBE -> sram_we_n, busrq_n, sram_ce_n high and bus_own=0 immediately; no done pulse.
- With CACHE_LOADER_CHECKSUM_EN: bytes 00..0F then checksum 78 -> done pulse; with checksum 77 -> err=1, no done pulse.
